// File: rtl/binserial.sv
// Bit-serial transmitter: loads an N-bit vector, pulses clr, then shifts it out LSB first on put/data_out.
// Define BINSERIAL_XNOR_EN to transmit ~(vec_in ^ wgt_in) instead of vec_in.
module binserial #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] vec_in,
  input  logic [N-1:0] wgt_in,
  output logic         clr,
  output logic         put,
  output logic         data_out,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   shift_q, shift_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   payload;
  logic           clr_d, put_d, data_d, busy_d, done_d;

`ifdef BINSERIAL_XNOR_EN
  assign payload = ~(vec_in ^ wgt_in);
`else
  logic unused_wgt;
  assign unused_wgt = ^wgt_in;
  assign payload    = vec_in;
`endif

  // NOTE: every output is computed one state ahead and registered, so each
  // branch drives the values that must appear after the coming edge.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    clr_d   = 1'b0;
    put_d   = 1'b1;
    data_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          shift_d = payload;
          cnt_d   = '0;
          clr_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_SHIFT;
        put_d   = 1'b0;
        data_d  = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = CW'(1);
        busy_d  = 1'b1;
      end
      S_SHIFT: begin
        busy_d = 1'b1;
        if (cnt_q == CW'(N)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          put_d   = 1'b0;
          data_d  = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      clr      <= 1'b0;
      put      <= 1'b1;
      data_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      clr      <= clr_d;
      put      <= put_d;
      data_out <= data_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule
